// File: rtl/level_gen.sv
// Rebuilds a clean level from one-cycle rise/fall requests, enforcing a minimum
// hold time, buffering one pending change and cancelling glitch pairs.
module level_gen #(
    parameter int unsigned MIN_HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic rise_i,
    input  logic fall_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o,
    output logic pend_o,
    output logic err_o
);

    localparam int unsigned HW = $clog2(MIN_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_HOLD - 1);

    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] cnt_n;
    logic          pend_v;
    logic          pend_n;
    logic          lvl_n;
    logic          err_n;
    logic          rel;
    logic          target;

    // Pending release is resolved first; the request then sees the post-release target.
    always_comb begin
        lvl_n  = level_o;
        pend_n = pend_v;
        cnt_n  = (hold_cnt != '0) ? hold_cnt - HW'(1) : '0;
        err_n  = 1'b0;
        rel    = pend_v && (hold_cnt == '0);

        if (rel) begin
            lvl_n  = ~level_o;
            pend_n = 1'b0;
            cnt_n  = HOLD_LOAD;
        end

        target = pend_n ? ~lvl_n : lvl_n;

        if (rise_i && fall_i) begin
            err_n = 1'b1;
        end else if (rise_i || fall_i) begin
            if (rise_i == target) begin
                err_n = 1'b1;
            end else if (pend_n) begin
                pend_n = 1'b0;
            end else if (!rel && (hold_cnt == '0)) begin
                lvl_n = ~lvl_n;
                cnt_n = HOLD_LOAD;
            end else begin
                pend_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_o  <= 1'b0;
            rise_o   <= 1'b0;
            fall_o   <= 1'b0;
            err_o    <= 1'b0;
            pend_v   <= 1'b0;
            hold_cnt <= '0;
        end else begin
            level_o  <= lvl_n;
            rise_o   <= lvl_n & ~level_o;
            fall_o   <= ~lvl_n & level_o;
            err_o    <= err_n;
            pend_v   <= pend_n;
            hold_cnt <= cnt_n;
        end
    end

    assign busy_o = (hold_cnt != '0);
    assign pend_o = pend_v;

endmodule

// File: tb/tb_level_gen.sv
// Directed bench for level_gen: one instance with MIN_HOLD=4, one with MIN_HOLD=1.
module tb_level_gen;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rise4 = 1'b0, fall4 = 1'b0, rise1 = 1'b0, fall1 = 1'b0;
    logic level4, rise_o4, fall_o4, busy4, pend4, err4;
    logic level1, rise_o1, fall_o1, busy1, pend1, err1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    level_gen #(.MIN_HOLD(4)) u4 (
        .clk(clk), .reset(reset), .rise_i(rise4), .fall_i(fall4),
        .level_o(level4), .rise_o(rise_o4), .fall_o(fall_o4),
        .busy_o(busy4), .pend_o(pend4), .err_o(err4)
    );

    level_gen #(.MIN_HOLD(1)) u1 (
        .clk(clk), .reset(reset), .rise_i(rise1), .fall_i(fall1),
        .level_o(level1), .rise_o(rise_o1), .fall_o(fall_o1),
        .busy_o(busy1), .pend_o(pend1), .err_o(err1)
    );

    // Observation order: {level, rise, fall, busy, pend, err}
    function automatic logic [5:0] obs4();
        return {level4, rise_o4, fall_o4, busy4, pend4, err4};
    endfunction

    function automatic logic [5:0] obs1();
        return {level1, rise_o1, fall_o1, busy1, pend1, err1};
    endfunction

    task automatic do_reset();
        rise4 = 1'b0; fall4 = 1'b0; rise1 = 1'b0; fall1 = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rise4 = i[0]; fall4 = ~i[0]; rise1 = ~i[0]; fall1 = i[0];
            @(posedge clk); #1;
            n_tests++;
            if (obs4() !== 6'b000000) begin
                n_fail++;
                $display("FAIL reset_h4 cyc%0d: got %b want 000000", i, obs4());
            end
            n_tests++;
            if (obs1() !== 6'b000000) begin
                n_fail++;
                $display("FAIL reset_h1 cyc%0d: got %b want 000000", i, obs1());
            end
        end
        rise4 = 1'b0; fall4 = 1'b0; rise1 = 1'b0; fall1 = 1'b0;
        reset = 1'b1;
    endtask

    // Each entry: {rise, fall, expected obs after the edge}
    task automatic test_basic_hold();
        logic [7:0] v [8] = '{8'b10_110100, 8'b00_100100, 8'b01_100110, 8'b00_100010,
                              8'b00_001100, 8'b00_000100, 8'b00_000100, 8'b00_000000};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rise4 = v[i][7]; fall4 = v[i][6];
            @(posedge clk); #1;
            rise4 = 1'b0; fall4 = 1'b0;
            n_tests++;
            if (obs4() !== v[i][5:0]) begin
                n_fail++;
                $display("FAIL basic_hold cyc%0d: got %b want %b", i, obs4(), v[i][5:0]);
            end
        end
    endtask

    task automatic test_glitch_cancel();
        logic [7:0] v [5] = '{8'b10_110100, 8'b01_100110, 8'b10_100100,
                              8'b00_100000, 8'b00_100000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rise4 = v[i][7]; fall4 = v[i][6];
            @(posedge clk); #1;
            rise4 = 1'b0; fall4 = 1'b0;
            n_tests++;
            if (obs4() !== v[i][5:0]) begin
                n_fail++;
                $display("FAIL glitch_cancel cyc%0d: got %b want %b", i, obs4(), v[i][5:0]);
            end
        end
    endtask

    // Redundant, conflicting, redundant-vs-pending and request-on-release cases
    task automatic test_errors();
        logic [7:0] v [17] = '{8'b10_110100, 8'b00_100100, 8'b00_100100, 8'b00_100000,
                               8'b10_100001, 8'b00_100000, 8'b11_100001, 8'b00_100000,
                               8'b01_001100, 8'b10_000110, 8'b10_000111, 8'b00_000010,
                               8'b01_110110, 8'b00_100110, 8'b00_100110, 8'b00_100010,
                               8'b00_001100};
        do_reset();
        for (int i = 0; i < 17; i++) begin
            rise4 = v[i][7]; fall4 = v[i][6];
            @(posedge clk); #1;
            rise4 = 1'b0; fall4 = 1'b0;
            n_tests++;
            if (obs4() !== v[i][5:0]) begin
                n_fail++;
                $display("FAIL errors cyc%0d: got %b want %b", i, obs4(), v[i][5:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rise4 = 1'b1;
        @(posedge clk); #1;
        rise4 = 1'b0; fall4 = 1'b1;
        @(posedge clk); #1;
        fall4 = 1'b0;
        n_tests++;
        if (obs4() !== 6'b100110) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got %b want 100110", obs4());
        end
        reset = 1'b0;
        #2;
        n_tests++;
        if (obs4() !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b want 000000", obs4());
        end
        reset = 1'b1;
        rise4 = 1'b1;
        @(posedge clk); #1;
        rise4 = 1'b0;
        n_tests++;
        if (obs4() !== 6'b110100) begin
            n_fail++;
            $display("FAIL reset_mid_first_req: got %b want 110100", obs4());
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_o;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rise1 = ~i[0]; fall1 = i[0];
            exp_o = i[0] ? 6'b001000 : 6'b110000;
            @(posedge clk); #1;
            rise1 = 1'b0; fall1 = 1'b0;
            n_tests++;
            if (obs1() !== exp_o) begin
                n_fail++;
                $display("FAIL back_to_back_h1 cyc%0d: got %b want %b", i, obs1(), exp_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_hold();
        test_glitch_cancel();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
